aligning_deserializer: RTL and testbench
========================================

Name: aligning_deserializer

Overview:
- Next-generation LSB-first serial-to-parallel converter for the ETROC2 readout path, running entirely in the bitCK domain.
- Adds automatic word alignment to the programmable-delay deserializer: a fixed header field in every word is searched, and the word boundary bit-slips until a lock FSM declares alignment.
- Descrambling stays downstream and consumes dout on wordValid.

Parameters:
- WORDWIDTH, 40, bits per word.
- WIDTH, 6, counter/delay/slip width; must be at least clog2(WORDWIDTH).
- HDRWIDTH, 8, header field width.
- HDRPOS, 32, LSB index of header field within the word; HDRPOS+HDRWIDTH must not exceed WORDWIDTH.
- HDR, 8'hA5, expected header value.
- LOCK_N, 4, consecutive good headers required to lock; must be at least 1.
- UNLOCK_N, 3, consecutive bad headers required to lose lock; must be at least 1.

Ports:
- bitCK  in  1  bit clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- sin  in  1  serial data, LSB of each word first.
- delay  in  WIDTH  input delay in bit periods; values >= WORDWIDTH clamp to WORDWIDTH-1.
- enAlign  in  1  1 = automatic alignment; 0 = manual mode.
- manualSlip  in  1  single-cycle slip request, honoured only when enAlign=0.
- dout  out  WORDWIDTH  last captured word.
- wordValid  out  1  one-cycle strobe coinciding with each dout update.
- wordCK  out  1  divided clock: registered high while bit counter >= WORDWIDTH/2.
- aligned  out  1  lock state is LOCKED.
- slipCount  out  WIDTH  cumulative slips, modulo WORDWIDTH.

Behaviour:
- Reset (synchronous, active-high) clears on the next edge:
  - dout, wordValid, wordCK, aligned, slipCount, bit counter, delay line, shift register and the pending-slip flag all go to 0.
  - FSM goes to SEARCH.
  - Reset asserted mid-operation behaves identically.
- Delay line:
  - 1-bit shift of sin, WORDWIDTH deep.
  - delayedS = sin when delay=0, else delay line tap [delay-1].
- Shift register: each edge, r <= {delayedS, r[WORDWIDTH-1:1]}.
- Bit counter:
  - Counts 0..WORDWIDTH-1 and wraps to 0.
  - The boundary edge is the edge where counter == WORDWIDTH-1.
- Slip:
  - When a slip is pending at a boundary edge, the counter holds at WORDWIDTH-1 for exactly one extra edge.
  - This moves the boundary one bit later.
  - The capture happens only on the second (non-held) edge.
  - slipCount increments, wrapping WORDWIDTH-1 -> 0.
  - At most one slip per word; multiple requests before a boundary merge into one.
- Capture:
  - On a non-held boundary edge, dout <= {delayedS, r[WORDWIDTH-1:1]} and wordValid = 1 for that following cycle only.
  - Latency: the last bit of a word on sin (delay=0) appears in dout after one edge.
- Header check: good = (captured word[HDRPOS+HDRWIDTH-1:HDRPOS] == HDR); evaluated once per capture.
- FSM (advances only on capture; counters goodCnt/badCnt):
  - SEARCH:
    - bad -> request slip, stay.
    - good -> goodCnt=1, then LOCKED if LOCK_N==1, else CHECK.
  - CHECK:
    - good -> goodCnt++; on reaching LOCK_N go to LOCKED with badCnt=0.
    - bad -> request slip, go to SEARCH.
  - LOCKED:
    - good -> badCnt=0.
    - bad -> badCnt++; on reaching UNLOCK_N go to SEARCH with no slip on this word.
  - aligned is registered and changes in the same cycle as the wordValid of the deciding word.
- Manual mode (enAlign=0):
  - FSM forced to SEARCH; aligned=0; no automatic slips.
  - A manualSlip pulse sets the pending-slip flag.
  - manualSlip is ignored while enAlign=1.
  - Toggling enAlign 0 -> 1 starts in SEARCH with counters cleared.
- wordCK: registered: 0 while counter < WORDWIDTH/2, else 1. The held slip edge keeps its previous value.

Decomposition:
- Shared package etroc2_readout_pkg:
  - lock state enum {SEARCH, CHECK, LOCKED}.
  - Default WORDWIDTH, header constants and LOCK_N/UNLOCK_N defaults.
- One sub-module, header_lock_fsm. Inputs: capture strobe, good, enAlign. Outputs: slipReq, aligned.
- Delay line, shift register, counter and capture stay in the top module.

Test Plan (WORDWIDTH=40, HDRPOS=32, HDR=8'hA5, payload 0 unless noted):
- Words with header A5 aligned to the reset boundary, delay=0, enAlign=1 -> no slips, slipCount=0; aligned rises with the 4th wordValid; dout=40'hA5_0000_0000.
- Same stream offset 13 bits later -> slipCount reaches 13, then aligned after 4 further good words; dout header=A5 thereafter.
- Locked; inject 2 bad headers then good -> aligned stays 1. Then 3 consecutive bad -> aligned=0 with the 3rd bad wordValid; search resumes with a slip on the next bad word.
- Locked at delay=0, change delay to 5 -> lock lost after 3 words; relocks with slipCount advanced by 5 mod 40.
- enAlign=0, misaligned stream, two manualSlip pulses within one word -> slipCount=1, aligned=0, no further slips.
- Reset asserted for 1 cycle while locked -> next edge: aligned=0, dout=0, wordValid=0, slipCount=0, state SEARCH; relocks normally afterwards.

Source files
------------

// File: rtl/etroc2_readout_pkg.sv
// Shared types and default parameters for the ETROC2 readout deserializer path.
package etroc2_readout_pkg;

    localparam int unsigned WORDWIDTH_DEF = 40;
    localparam int unsigned WIDTH_DEF     = 6;
    localparam int unsigned HDRWIDTH_DEF  = 8;
    localparam int unsigned HDRPOS_DEF    = 32;
    localparam logic [7:0]  HDR_DEF       = 8'hA5;
    localparam int unsigned LOCK_N_DEF    = 4;
    localparam int unsigned UNLOCK_N_DEF  = 3;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    // Bits needed to hold a count from 0 up to n inclusive.
    function automatic int unsigned cnt_bits(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/header_lock_fsm.sv
// Header-based word lock tracker: decides alignment and requests bit slips while searching.
module header_lock_fsm
    import etroc2_readout_pkg::*;
#(
    parameter int unsigned LOCK_N   = LOCK_N_DEF,
    parameter int unsigned UNLOCK_N = UNLOCK_N_DEF
) (
    input  logic bitCK,
    input  logic reset,
    input  logic capture,
    input  logic good,
    input  logic enAlign,
    output logic slipReq,
    output logic aligned
);

    localparam int unsigned CW = cnt_bits((LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N);
    localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_N - 1);
    localparam logic [CW-1:0] UNLOCK_LAST = CW'(UNLOCK_N - 1);

    lock_state_e state_q, state_d;
    logic [CW-1:0] good_q, good_d, bad_q, bad_d;
    logic slip_d, aligned_d;

    always_ff @(posedge bitCK) begin
        if (reset) begin
            state_q <= SEARCH;
            good_q  <= '0;
            bad_q   <= '0;
            slipReq <= 1'b0;
            aligned <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            slipReq <= slip_d;
            aligned <= aligned_d;
        end
    end

    // Transitions happen only on a captured word; manual mode pins the tracker in SEARCH.
    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        bad_d   = bad_q;
        slip_d  = 1'b0;
        if (!enAlign) begin
            state_d = SEARCH;
            good_d  = '0;
            bad_d   = '0;
        end else if (capture) begin
            case (state_q)
                SEARCH: begin
                    if (good) begin
                        good_d  = CW'(1);
                        bad_d   = '0;
                        state_d = (LOCK_N == 1) ? LOCKED : CHECK;
                    end else begin
                        good_d = '0;
                        slip_d = 1'b1;
                    end
                end
                CHECK: begin
                    if (good) begin
                        if (good_q == LOCK_LAST) begin
                            state_d = LOCKED;
                            bad_d   = '0;
                        end else begin
                            good_d = good_q + 1'b1;
                        end
                    end else begin
                        state_d = SEARCH;
                        good_d  = '0;
                        slip_d  = 1'b1;
                    end
                end
                LOCKED: begin
                    if (good) begin
                        bad_d = '0;
                    end else if (bad_q == UNLOCK_LAST) begin
                        state_d = SEARCH;
                        good_d  = '0;
                        bad_d   = '0;
                    end else begin
                        bad_d = bad_q + 1'b1;
                    end
                end
                default: begin
                    state_d = SEARCH;
                    good_d  = '0;
                    bad_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        aligned_d = (state_d == LOCKED);
    end

endmodule

// File: rtl/aligning_deserializer.sv
// LSB-first serial-to-parallel converter with programmable input delay and header-driven bit-slip alignment.
module aligning_deserializer
    import etroc2_readout_pkg::*;
#(
    parameter int unsigned WORDWIDTH         = WORDWIDTH_DEF,
    parameter int unsigned WIDTH             = WIDTH_DEF,
    parameter int unsigned HDRWIDTH          = HDRWIDTH_DEF,
    parameter int unsigned HDRPOS            = HDRPOS_DEF,
    parameter logic [HDRWIDTH-1:0] HDR       = HDR_DEF,
    parameter int unsigned LOCK_N            = LOCK_N_DEF,
    parameter int unsigned UNLOCK_N          = UNLOCK_N_DEF
) (
    input  logic                 bitCK,
    input  logic                 reset,
    input  logic                 sin,
    input  logic [WIDTH-1:0]     delay,
    input  logic                 enAlign,
    input  logic                 manualSlip,
    output logic [WORDWIDTH-1:0] dout,
    output logic                 wordValid,
    output logic                 wordCK,
    output logic                 aligned,
    output logic [WIDTH-1:0]     slipCount
);

    localparam int unsigned IDX_W = $clog2(WORDWIDTH);
    localparam logic [WIDTH-1:0] LAST = WIDTH'(WORDWIDTH - 1);
    localparam logic [WIDTH-1:0] HALF = WIDTH'(WORDWIDTH / 2);

    logic [WORDWIDTH-1:0] dline, sreg, word_c;
    logic [WIDTH-1:0]     cnt, dly_eff_c;
    logic                 hold, slip_pend, slip_req;
    logic                 delayed_s_c, boundary_c, slip_now_c, capture_c, good_c;

    // Delay tap selection, boundary detection and the word about to be captured.
    always_comb begin
        dly_eff_c   = (32'(delay) >= WORDWIDTH) ? LAST : delay;
        delayed_s_c = (dly_eff_c == '0) ? sin : dline[IDX_W'(dly_eff_c - 1'b1)];
        boundary_c  = (cnt == LAST);
        slip_now_c  = boundary_c && !hold && slip_pend;
        capture_c   = boundary_c && !slip_now_c;
        word_c      = {delayed_s_c, sreg[WORDWIDTH-1:1]};
        good_c      = (word_c[HDRPOS +: HDRWIDTH] == HDR);
    end

    always_ff @(posedge bitCK) begin
        if (reset) begin
            dline     <= '0;
            sreg      <= '0;
            cnt       <= '0;
            hold      <= 1'b0;
            slip_pend <= 1'b0;
            dout      <= '0;
            wordValid <= 1'b0;
            wordCK    <= 1'b0;
            slipCount <= '0;
        end else begin
            dline     <= {dline[WORDWIDTH-2:0], sin};
            sreg      <= word_c;
            wordValid <= capture_c;
            hold      <= slip_now_c;
            if (capture_c) begin
                dout <= word_c;
            end
            // A slip stretches the boundary by one edge; the counter stays at LAST.
            if (slip_now_c) begin
                slipCount <= (slipCount == LAST) ? '0 : slipCount + 1'b1;
            end else begin
                wordCK <= (cnt >= HALF);
                cnt    <= boundary_c ? '0 : cnt + 1'b1;
            end
            slip_pend <= (slip_pend && !slip_now_c) || slip_req || (manualSlip && !enAlign);
        end
    end

    header_lock_fsm #(
        .LOCK_N   (LOCK_N),
        .UNLOCK_N (UNLOCK_N)
    ) u_lock (
        .bitCK   (bitCK),
        .reset   (reset),
        .capture (capture_c),
        .good    (good_c),
        .enAlign (enAlign),
        .slipReq (slip_req),
        .aligned (aligned)
    );

endmodule

// File: tb/tb_aligning_deserializer.sv
// Directed bench for aligning_deserializer: word table plus slip, delay, manual and reset sequences.
module tb_aligning_deserializer;

    localparam int unsigned WW = 40;

    logic          bitCK = 1'b0;
    logic          reset = 1'b1;
    logic          sin = 1'b0;
    logic [5:0]    delay = 6'd0;
    logic          enAlign = 1'b1;
    logic          manualSlip = 1'b0;
    logic [WW-1:0] dout;
    logic          wordValid;
    logic          wordCK;
    logic          aligned;
    logic [5:0]    slipCount;

    int errors = 0;
    int checks = 0;
    int sidx = 0;
    logic [WW-1:0] good_w = {8'hA5, 32'h0};

    aligning_deserializer dut (
        .bitCK      (bitCK),
        .reset      (reset),
        .sin        (sin),
        .delay      (delay),
        .enAlign    (enAlign),
        .manualSlip (manualSlip),
        .dout       (dout),
        .wordValid  (wordValid),
        .wordCK     (wordCK),
        .aligned    (aligned),
        .slipCount  (slipCount)
    );

    always #5 bitCK = ~bitCK;

    typedef struct {
        logic [7:0]  hdr;
        logic [31:0] payload;
        logic        exp_al;
        logic [5:0]  exp_sc;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one bit, let one edge pass, then settle away from the edge.
    task automatic tick(input logic b);
        sin = b;
        @(posedge bitCK);
        #1;
    endtask

    task automatic stream_tick();
        tick(good_w[6'(sidx % WW)]);
        sidx++;
    endtask

    task automatic send_word(input logic [WW-1:0] w, output int early);
        early = 0;
        for (int i = 0; i < WW; i++) begin
            tick(w[i]);
            if (i < WW - 1 && wordValid) early++;
        end
    endtask

    initial begin
        int early, nv, v13, ncap, drop_at, exp_k;

        vt[0]  = '{8'hA5, 32'h0000_0000, 1'b0, 6'd0};
        vt[1]  = '{8'hA5, 32'h0000_0000, 1'b0, 6'd0};
        vt[2]  = '{8'hA5, 32'h1234_5678, 1'b0, 6'd0};
        vt[3]  = '{8'hA5, 32'h0000_0000, 1'b1, 6'd0};
        vt[4]  = '{8'h3C, 32'h0000_0000, 1'b1, 6'd0};
        vt[5]  = '{8'hA4, 32'hDEAD_BEEF, 1'b1, 6'd0};
        vt[6]  = '{8'hA5, 32'h0000_0000, 1'b1, 6'd0};
        vt[7]  = '{8'h00, 32'h0000_0000, 1'b1, 6'd0};
        vt[8]  = '{8'h5A, 32'h0000_0000, 1'b1, 6'd0};
        vt[9]  = '{8'hFF, 32'h0000_0001, 1'b0, 6'd0};
        vt[10] = '{8'h00, 32'h0000_0000, 1'b0, 6'd0};

        // Reset state
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        chk("rst_dout", 64'(dout), 64'h0);
        chk("rst_valid", 64'(wordValid), 64'h0);
        chk("rst_aligned", 64'(aligned), 64'h0);
        chk("rst_slipcount", 64'(slipCount), 64'h0);
        chk("rst_wordck", 64'(wordCK), 64'h0);

        // Aligned words: lock, tolerate two bad, unlock on three bad
        for (int v = 0; v < 11; v++) begin
            send_word({vt[v].hdr, vt[v].payload}, early);
            chk($sformatf("vec%0d_early_valid", v), 64'(early), 64'h0);
            chk($sformatf("vec%0d_valid", v), 64'(wordValid), 64'h1);
            chk($sformatf("vec%0d_dout", v), 64'(dout), 64'({vt[v].hdr, vt[v].payload}));
            chk($sformatf("vec%0d_aligned", v), 64'(aligned), 64'(vt[v].exp_al));
            chk($sformatf("vec%0d_slipcount", v), 64'(slipCount), 64'(vt[v].exp_sc));
        end

        // Bad word in SEARCH: next boundary is held for one edge
        nv = 0;
        for (int i = 0; i < WW - 1; i++) begin
            tick(1'b0);
            if (wordValid) nv++;
        end
        chk("slip_no_early_valid", 64'(nv), 64'h0);
        tick(1'b0);
        chk("slip_hold_valid", 64'(wordValid), 64'h0);
        chk("slip_count_one", 64'(slipCount), 64'h1);
        tick(1'b0);
        chk("slip_capture_valid", 64'(wordValid), 64'h1);

        // Stream 13 bits late: 13 slips then four good words
        reset = 1'b1;
        tick(1'b0);
        reset = 1'b0;
        for (int i = 0; i < 13; i++) tick(1'b0);
        sidx = 0;
        v13 = 0;
        for (int i = 0; i < 3000 && !aligned; i++) begin
            stream_tick();
            if (wordValid && slipCount == 6'd13) v13++;
        end
        chk("off13_aligned", 64'(aligned), 64'h1);
        chk("off13_slipcount", 64'(slipCount), 64'd13);
        chk("off13_good_words", 64'(v13), 64'd4);
        chk("off13_dout", 64'(dout), 64'(good_w));
        for (int i = 0; i < 2 * WW; i++) stream_tick();
        chk("off13_stays_locked", 64'(aligned), 64'h1);

        // Delay step of 5: drop after three bad words, relock five slips later
        delay = 6'd5;
        ncap = 0;
        drop_at = 0;
        for (int i = 0; i < 4000 && !(drop_at != 0 && aligned); i++) begin
            stream_tick();
            if (wordValid) begin
                ncap++;
                if (!aligned && drop_at == 0) drop_at = ncap;
            end
        end
        chk("dly5_drop_word", 64'(drop_at), 64'd3);
        chk("dly5_relock", 64'(aligned), 64'h1);
        chk("dly5_slipcount", 64'(slipCount), 64'd18);
        chk("dly5_dout", 64'(dout), 64'(good_w));

        // One-cycle reset while locked, then relock from a known phase
        delay = 6'd0;
        reset = 1'b1;
        stream_tick();
        reset = 1'b0;
        chk("midrst_aligned", 64'(aligned), 64'h0);
        chk("midrst_dout", 64'(dout), 64'h0);
        chk("midrst_valid", 64'(wordValid), 64'h0);
        chk("midrst_slipcount", 64'(slipCount), 64'h0);
        exp_k = (WW - (sidx % WW)) % WW;
        for (int i = 0; i < 3000 && !aligned; i++) stream_tick();
        chk("midrst_relock", 64'(aligned), 64'h1);
        chk("midrst_slipcount_relock", 64'(slipCount), 64'(exp_k));
        chk("midrst_dout_relock", 64'(dout), 64'(good_w));

        // Manual mode: two pulses within one word merge into one slip
        enAlign = 1'b0;
        stream_tick();
        chk("man_aligned_drop", 64'(aligned), 64'h0);
        reset = 1'b1;
        stream_tick();
        reset = 1'b0;
        nv = 0;
        for (int i = 0; i < 100 && nv == 0; i++) begin
            stream_tick();
            if (wordValid) nv++;
        end
        chk("man_first_word", 64'(nv), 64'h1);
        manualSlip = 1'b1;
        stream_tick();
        manualSlip = 1'b0;
        for (int i = 0; i < 3; i++) stream_tick();
        manualSlip = 1'b1;
        stream_tick();
        manualSlip = 1'b0;
        nv = 0;
        for (int i = 0; i < 3 * WW; i++) begin
            stream_tick();
            if (aligned) nv++;
        end
        chk("man_slipcount", 64'(slipCount), 64'h1);
        chk("man_never_aligned", 64'(nv), 64'h0);

        // Back to automatic alignment
        enAlign = 1'b1;
        for (int i = 0; i < 3000 && !aligned; i++) stream_tick();
        chk("auto_relock", 64'(aligned), 64'h1);
        chk("auto_dout", 64'(dout), 64'(good_w));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
